// File: rtl/bram_snapshot_if.sv
// bram_snapshot_if
// Bundles the capture-control, sample-stream and BRAM-write-port signals of
// bram_snapshot_ctrl.
//   master modport : the host side. Drives arm/len/trig/din/din_valid and
//                    observes the write port and status.
//   slave modport  : the controller side (bram_snapshot_ctrl).
// Handshake semantics: a sample is accepted on a rising clk edge where
// din_valid is high and the controller is armed (with trig) or capturing.
// There is no back-pressure. bram_wr is a one-cycle write strobe, and
// bram_addr/bram_data are meaningful only while it is high.
interface bram_snapshot_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  arm;
    logic [ADDR_WIDTH-1:0] len;
    logic                  trig;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  bram_wr;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   wr_count;

    modport master (
        output arm, len, trig, din, din_valid,
        input  bram_wr, bram_addr, bram_data, busy, done, wr_count
    );

    modport slave (
        input  arm, len, trig, din, din_valid,
        output bram_wr, bram_addr, bram_data, busy, done, wr_count
    );
endinterface

// File: rtl/bram_snapshot_ctrl.sv
// bram_snapshot_ctrl
// Arms on command, waits for a trigger that coincides with a valid sample,
// then writes a programmed number of consecutive valid samples into a BRAM
// write port at addresses 0..N-1. After the last write it holds done so the
// other RAM port can drain the buffer.
// Ports:
//   clk       : single clock, also clocks the BRAM write port
//   rst_n     : synchronous reset, active-low
//   bus       : bram_snapshot_if.slave (arm/len/trig/din/din_valid in;
//               bram_wr/bram_addr/bram_data/busy/done/wr_count out)
//   state_dbg : current FSM state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE)
module bram_snapshot_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_snapshot_if.slave      bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Full-depth value of target, used when len == 0 and after reset.
    localparam logic [ADDR_WIDTH:0] FULL_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH:0]   target_q,    target_d;
    logic [ADDR_WIDTH:0]   wr_count_q,  wr_count_d;
    logic                  bram_wr_q,   bram_wr_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_data_q, bram_data_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  accept;
    logic                  do_arm;
    logic [ADDR_WIDTH:0]   wr_count_inc;

    assign wr_count_inc = wr_count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        wr_count_d  = wr_count_q;
        bram_wr_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        accept      = 1'b0;
        do_arm      = 1'b0;

        case (state_q)
            // trig is not looked at while arming, so arm+trig only arms.
            IDLE:    do_arm = bus.arm;
            ARMED:   accept = bus.trig && bus.din_valid;
            CAPTURE: accept = bus.din_valid;
            DONE:    do_arm = bus.arm;
            default: ;
        endcase

        if (do_arm) begin
            state_d    = ARMED;
            target_d   = (bus.len == '0) ? FULL_DEPTH : {1'b0, bus.len};
            wr_count_d = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
        end

        if (accept) begin
            bram_wr_d   = 1'b1;
            bram_addr_d = wr_count_q[ADDR_WIDTH-1:0];
            bram_data_d = bus.din;
            wr_count_d  = wr_count_inc;
            state_d     = CAPTURE;
            // done rises on the same edge as the final write strobe.
            if (wr_count_inc == target_q) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= FULL_DEPTH;
            wr_count_q  <= '0;
            bram_wr_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            wr_count_q  <= wr_count_d;
            bram_wr_q   <= bram_wr_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.bram_wr   = bram_wr_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_data = bram_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_count  = wr_count_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_bram_snapshot_ctrl.sv
// tb_bram_snapshot_ctrl
// Bench for bram_snapshot_ctrl at ADDR_WIDTH=4, DATA_WIDTH=8. Each scenario
// task pushes the {addr, data} writes it expects into exp_q. A negedge
// monitor pops one entry per bram_wr pulse and compares it. Status outputs
// are checked inline by the tasks.
module tb_bram_snapshot_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk;
    logic rst_n;
    logic [1:0] state_dbg;

    bram_snapshot_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_snapshot_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int errors = 0;
    int checks = 0;
    logic [AW+DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.bram_wr === 1'b1) begin
            logic [AW+DW-1:0] got;
            logic [AW+DW-1:0] exp;
            got = {bus.bram_addr, bus.bram_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                         bus.bram_addr, bus.bram_data);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             got[AW+DW-1:DW], got[DW-1:0], exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Applies one cycle of inputs, then returns 1 time unit after the edge.
    task automatic cyc(input logic a, input logic [AW-1:0] l, input logic t,
                       input logic [DW-1:0] d, input logic v);
        bus.arm       = a;
        bus.len       = l;
        bus.trig      = t;
        bus.din       = d;
        bus.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic push_exp(input int addr, input logic [DW-1:0] data);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        exp_q.push_back({a, data});
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_cycles(3);
        checks++; if (bus.bram_wr !== 1'b0) begin errors++; $display("FAIL rst_bram_wr: got %0b required 0", bus.bram_wr); end
        checks++; if (bus.bram_addr !== 4'h0) begin errors++; $display("FAIL rst_bram_addr: got %0h required 0", bus.bram_addr); end
        checks++; if (bus.bram_data !== 8'h00) begin errors++; $display("FAIL rst_bram_data: got %0h required 0", bus.bram_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b required 0", bus.done); end
        checks++; if (bus.wr_count !== 5'd0) begin errors++; $display("FAIL rst_wr_count: got %0d required 0", bus.wr_count); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
        rst_n = 1'b1;
        // trig with valid in IDLE must not start anything.
        cyc(1'b0, '0, 1'b1, 8'h99, 1'b1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_trig_busy: got %0b required 0", bus.busy); end
        idle_cycles(1);
    endtask

    task automatic test_basic();
        cyc(1'b1, 4'd5, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b required 1", bus.busy); end
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL basic_armed: got %0d required 1", state_dbg); end
        for (int i = 0; i < 5; i++) push_exp(i, 8'h13 + 8'(i));
        for (int d = 'h10; d <= 'h1F; d++) begin
            cyc(1'b0, '0, (d == 'h13), 8'(d), 1'b1);
            if (d == 'h16) begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %0b required 0", bus.done); end
            end
            if (d == 'h17) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b required 1", bus.done); end
                checks++; if (bus.bram_wr !== 1'b1 || bus.bram_addr !== 4'd4) begin errors++; $display("FAIL basic_last_wr: got wr=%0b addr=%0h required wr=1 addr=4", bus.bram_wr, bus.bram_addr); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_low: got %0b required 0", bus.busy); end
                checks++; if (bus.wr_count !== 5'd5) begin errors++; $display("FAIL basic_wr_count: got %0d required 5", bus.wr_count); end
            end
        end
        idle_cycles(2);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd5) begin errors++; $display("FAIL basic_hold: got done=%0b count=%0d required done=1 count=5", bus.done, bus.wr_count); end
        check_drained("basic");
    endtask

    task automatic test_full_depth();
        logic [DW-1:0] vals[16];
        for (int i = 0; i < 16; i++) vals[i] = 8'($urandom_range(0, 255));
        cyc(1'b1, 4'd0, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.done !== 1'b0 || bus.wr_count !== 5'd0) begin errors++; $display("FAIL full_rearm: got done=%0b count=%0d required done=0 count=0", bus.done, bus.wr_count); end
        for (int i = 0; i < 16; i++) push_exp(i, vals[i]);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, '0, (i == 0), vals[i], 1'b1);
            if (i == 14) begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %0b required 0", bus.done); end
            end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b required 1", bus.done); end
        checks++; if (bus.wr_count !== 5'd16) begin errors++; $display("FAIL full_wr_count: got %0d required 16", bus.wr_count); end
        cyc(1'b0, '0, 1'b1, 8'h77, 1'b1);
        idle_cycles(1);
        check_drained("full");
    endtask

    task automatic test_trig_gap();
        cyc(1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, '0, 1'b1, 8'h55, 1'b0);
        cyc(1'b0, '0, 1'b0, 8'h66, 1'b1);
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL gap_still_armed: got %0d required 1", state_dbg); end
        push_exp(0, 8'hAA);
        push_exp(1, 8'hB1);
        push_exp(2, 8'hB2);
        push_exp(3, 8'hB3);
        cyc(1'b0, '0, 1'b1, 8'hAA, 1'b1);
        cyc(1'b0, '0, 1'b0, 8'hB1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 8'hEE, 1'b0);
            checks++; if (bus.bram_wr !== 1'b0) begin errors++; $display("FAIL gap_wr_low: got %0b required 0", bus.bram_wr); end
        end
        cyc(1'b0, '0, 1'b0, 8'hB2, 1'b1);
        cyc(1'b0, '0, 1'b0, 8'hB3, 1'b1);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd4) begin errors++; $display("FAIL gap_done: got done=%0b count=%0d required done=1 count=4", bus.done, bus.wr_count); end
        idle_cycles(2);
        check_drained("gap");
    endtask

    task automatic test_arm_ignored_and_rearm();
        cyc(1'b1, 4'd6, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) push_exp(i, 8'h20 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            cyc((i == 1), 4'd3, (i == 0), 8'h20 + 8'(i), 1'b1);
            if (i == 2) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midarm_busy: got %0b required 1", bus.busy); end
            end
        end
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd6) begin errors++; $display("FAIL midarm_count: got done=%0b count=%0d required done=1 count=6", bus.done, bus.wr_count); end
        check_drained("midarm");
        cyc(1'b1, 4'd2, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.done !== 1'b0 || bus.wr_count !== 5'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rearm: got done=%0b count=%0d busy=%0b required 0/0/1", bus.done, bus.wr_count, bus.busy); end
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, (i == 0), 8'h30 + 8'(i), 1'b1);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd2) begin errors++; $display("FAIL rearm_count: got done=%0b count=%0d required done=1 count=2", bus.done, bus.wr_count); end
        idle_cycles(1);
        check_drained("rearm");
    endtask

    task automatic test_reset_mid_capture();
        cyc(1'b1, 4'd8, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) push_exp(i, 8'h50 + 8'(i));
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, (i == 0), 8'h50 + 8'(i), 1'b1);
        rst_n = 1'b0;
        cyc(1'b1, 4'd2, 1'b0, 8'h53, 1'b1);
        checks++; if (bus.bram_wr !== 1'b0 || bus.bram_addr !== 4'h0 || bus.bram_data !== 8'h00) begin errors++; $display("FAIL midrst_port: got wr=%0b addr=%0h data=%0h required 0/0/0", bus.bram_wr, bus.bram_addr, bus.bram_data); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 5'd0) begin errors++; $display("FAIL midrst_status: got busy=%0b done=%0b count=%0d required 0/0/0", bus.busy, bus.done, bus.wr_count); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d required 0", state_dbg); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 8'h60 + 8'(i), 1'b1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_trig_ignored: got busy=%0b required 0", bus.busy); end
        check_drained("midrst");
    endtask

    task automatic test_arm_trig_same_cycle();
        cyc(1'b1, 4'd2, 1'b1, 8'h40, 1'b1);
        checks++; if (bus.busy !== 1'b1 || bus.bram_wr !== 1'b0) begin errors++; $display("FAIL same_arm: got busy=%0b wr=%0b required busy=1 wr=0", bus.busy, bus.bram_wr); end
        push_exp(0, 8'h41);
        push_exp(1, 8'h42);
        cyc(1'b0, '0, 1'b1, 8'h41, 1'b1);
        checks++; if (bus.bram_wr !== 1'b1 || bus.bram_addr !== 4'h0) begin errors++; $display("FAIL same_first: got wr=%0b addr=%0h required wr=1 addr=0", bus.bram_wr, bus.bram_addr); end
        cyc(1'b0, '0, 1'b0, 8'h42, 1'b1);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL same_done: got %0b required 1", bus.done); end
        idle_cycles(2);
        check_drained("same");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n         = 1'b0;
        bus.arm       = 1'b0;
        bus.len       = '0;
        bus.trig      = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        test_reset();
        test_basic();
        test_full_depth();
        test_trig_gap();
        test_arm_ignored_and_rearm();
        test_reset_mid_capture();
        test_arm_trig_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_snapshot_ctrl.md
# bram_snapshot_ctrl

Single-clock capture controller that sits directly upstream of the dual-port BRAM and drives its write port. It arms on command, waits for a qualified trigger, then writes a programmed number of consecutive valid samples into the RAM at addresses 0..N-1. After the last write it holds a done flag so the readout side (the other RAM port) can drain the buffer.

## Interface
- DATA_WIDTH, 32, sample width; matches the BRAM data width.
- ADDR_WIDTH, 10, BRAM address bits; buffer depth is 2**ADDR_WIDTH.
- clk  in  1  single clock for all logic; the same clock drives the BRAM write port.
- rst_n  in  1  synchronous reset, active-low.
- arm  in  1  single-cycle pulse to start a capture; latches len.
- len  in  ADDR_WIDTH  number of samples to capture; 0 means the full depth, 2**ADDR_WIDTH.
- trig  in  1  trigger; qualified by din_valid.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  sample strobe.
- bram_wr  out  1  write enable to the BRAM port.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_data  out  DATA_WIDTH  write data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_WIDTH+1  samples written in the current or last capture.

## Operation
- State machine with four states, encoded as 2 bits:
  - IDLE: arm goes to ARMED. trig and din_valid are ignored.
  - ARMED: trig && din_valid goes to CAPTURE; that sample is the first one written. trig without din_valid is ignored, with no latching.
  - CAPTURE: each din_valid cycle writes one sample. When the sample numbered target is written, go to DONE.
  - DONE: arm goes to ARMED and clears wr_count and done. Otherwise hold.
- arm in ARMED or CAPTURE is ignored. No retrigger and no length change mid-capture.
- On arm, target <= (len == 0) ? 2**ADDR_WIDTH : len. target is an internal register of ADDR_WIDTH+1 bits.
- Write datapath:
  - On each accepted sample: bram_data <= din, bram_addr <= wr_count[ADDR_WIDTH-1:0], bram_wr <= 1, wr_count <= wr_count + 1.
  - Otherwise bram_wr <= 0.
  - bram_addr and bram_data hold their last value when bram_wr is low.
- Address wrap: never occurs. target ≤ 2**ADDR_WIDTH, so the last address is target-1 ≤ 2**ADDR_WIDTH-1. wr_count reaches 2**ADDR_WIDTH only in a full-depth capture, which is why it carries one extra bit.
- Gaps in din_valid during CAPTURE stall the capture; there is no timeout.
- trig during CAPTURE or DONE is ignored.
- A new capture overwrites from address 0. Data beyond the new target is left untouched.

## Timing
- Reset values (rst_n low at a clk edge):
  - state = IDLE.
  - bram_wr = 0, bram_addr = 0, bram_data = 0.
  - busy = 0, done = 0, wr_count = 0.
  - target = 2**ADDR_WIDTH.
- Reset mid-capture aborts immediately. The partial buffer content is undefined to the reader and done stays 0.
- All outputs are registered.
- arm at edge k: busy = 1 after edge k.
- A qualified trigger sample presented before edge t:
  - bram_wr = 1, bram_addr = 0, bram_data = that din after edge t.
  - Sample written to the RAM at edge t+1.
- The last accepted sample enters its write register at edge f. At that same edge: state -> DONE, done = 1, busy = 0, wr_count = target.
  - done therefore rises together with the final bram_wr pulse.
  - The RAM holds the final word one edge after done rises. Readers must wait one cycle after done before reading the last address.
- Throughput: one sample per clock. Latency din -> bram_wr is 1 cycle.
- Simultaneous events:
  - arm and trig in IDLE or DONE: only the arm is taken. The trigger is not seen, because the state is not yet ARMED.
  - arm in DONE on the same cycle rst_n is low: reset wins.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=8, len=5. Pulse arm, send din 0x10..0x1F with valid every cycle, and assert trig with din=0x13 -> writes 0x13..0x17 to addr 0..4, done=1 together with the addr-4 write, wr_count=5, no further bram_wr.
- len=0 -> 16 writes at addr 0..15 with no wrap, wr_count=16, done after the 16th.
- Trigger with din_valid=0 in ARMED -> no capture. A later trig with din_valid=1 and din=0xAA -> addr 0 = 0xAA. A valid gap of 3 cycles mid-capture -> bram_wr low for 3 cycles, addresses stay contiguous.
- arm during CAPTURE with len=3 pending (original len=6) -> ignored, 6 writes. Then arm from DONE with len=2 -> done clears, wr_count=0, and the next trigger writes exactly 2 samples.
- rst_n low after the 3rd write of len=8 -> all outputs 0 and IDLE next cycle. trig afterwards does nothing until arm.
- arm and trig on the same cycle from IDLE -> busy=1, no write. A trig on the following cycle -> write at addr 0.
